// File: rtl/i2c_write_engine_if.sv
// i2c_write_engine_if
//   Request, status and bus-intent bundle for the I2C byte write engine.
//   master : the engine itself (consumes the request and SDA readback,
//            drives SCL/SDA open-drain intents and status)
//   slave  : the requesting FSM / bus side (issues start and byte fields,
//            returns SDA readback, observes status)
//   Signals: start, address[6:0], reg_addr[7:0], data[7:0], sda_in,
//            sda_out, scl_out, busy, finished, ack, nack_idx[1:0]
interface i2c_write_engine_if;
    logic       start;
    logic [6:0] address;
    logic [7:0] reg_addr;
    logic [7:0] data;
    logic       sda_in;
    logic       sda_out;
    logic       scl_out;
    logic       busy;
    logic       finished;
    logic       ack;
    logic [1:0] nack_idx;

    modport master (
        input  start, address, reg_addr, data, sda_in,
        output sda_out, scl_out, busy, finished, ack, nack_idx
    );

    modport slave (
        output start, address, reg_addr, data, sda_in,
        input  sda_out, scl_out, busy, finished, ack, nack_idx
    );
endinterface

// File: rtl/i2c_write_engine.sv
// i2c_write_engine
//   Byte-level I2C master write transmitter. On an accepted start it emits
//   START, {addr,W}, optionally reg_addr, then data, each followed by an ACK
//   slot, then STOP, and finally pulses finished with the ACK summary.
//   One slowclk cycle is one quarter of an SCL bit period.
//   Ports:
//     slowclk : engine clock
//     rstn    : asynchronous active-low reset (bus released, no STOP)
//     bus     : i2c_write_engine_if.master (request, SDA readback,
//               SCL/SDA open-drain intents where 1 = release, status)
//   Parameter SEND_REG: 1 = send reg_addr between address and data bytes.
module i2c_write_engine #(
    parameter bit SEND_REG = 1'b1
) (
    input  logic               slowclk,
    input  logic               rstn,
    i2c_write_engine_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, DONE} state_t;

    localparam logic [1:0] NO_NACK  = 2'd3;
    localparam logic [1:0] LAST_IDX = 2'd2;

    state_t     state;
    logic [1:0] phase;      // quarter-bit phase, also START/STOP cycle count
    logic [2:0] bit_cnt;
    logic [1:0] byte_idx;   // 0 = addr, 1 = reg, 2 = data
    logic [6:0] addr_q;
    logic [7:0] reg_q;
    logic [7:0] data_q;
    logic [7:0] cur_byte;

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = {addr_q, 1'b0};
            2'd1:    cur_byte = reg_q;
            default: cur_byte = data_q;
        endcase
    end

    // Outputs are registered from the current state, so the bus waveform
    // of a state appears one cycle after the state is entered.
    always_ff @(posedge slowclk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            phase        <= 2'd0;
            bit_cnt      <= 3'd7;
            byte_idx     <= 2'd0;
            addr_q       <= '0;
            reg_q        <= '0;
            data_q       <= '0;
            bus.sda_out  <= 1'b1;
            bus.scl_out  <= 1'b1;
            bus.busy     <= 1'b0;
            bus.finished <= 1'b0;
            bus.ack      <= 1'b0;
            bus.nack_idx <= NO_NACK;
        end else begin
            bus.finished <= 1'b0;
            case (state)
                IDLE: begin
                    bus.sda_out <= 1'b1;
                    bus.scl_out <= 1'b1;
                    bus.busy    <= 1'b0;
                    phase       <= 2'd0;
                    if (bus.start) begin
                        addr_q       <= bus.address;
                        reg_q        <= bus.reg_addr;
                        data_q       <= bus.data;
                        bus.ack      <= 1'b0;
                        bus.nack_idx <= NO_NACK;
                        bus.busy     <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    // SDA falls while SCL is still high, then SCL drops
                    bus.sda_out <= 1'b0;
                    bus.scl_out <= (phase == 2'd0);
                    if (phase == 2'd1) begin
                        phase    <= 2'd0;
                        byte_idx <= 2'd0;
                        bit_cnt  <= 3'd7;
                        state    <= BYTE;
                    end else begin
                        phase <= phase + 2'd1;
                    end
                end
                BYTE: begin
                    bus.sda_out <= cur_byte[bit_cnt];
                    bus.scl_out <= (phase == 2'd1) || (phase == 2'd2);
                    phase       <= phase + 2'd1;
                    if (phase == 2'd3) begin
                        // wraps 0 -> 7, ready for the next byte
                        bit_cnt <= bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) state <= ACK;
                    end
                end
                ACK: begin
                    bus.sda_out <= 1'b1;
                    bus.scl_out <= (phase == 2'd1) || (phase == 2'd2);
                    phase       <= phase + 2'd1;
                    if (phase == 2'd2 && bus.sda_in) bus.nack_idx <= byte_idx;
                    if (phase == 2'd3) begin
                        if (bus.nack_idx != NO_NACK || byte_idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            byte_idx <= (byte_idx == 2'd0 && !SEND_REG) ? 2'd2 : byte_idx + 2'd1;
                            state    <= BYTE;
                        end
                    end
                end
                STOP: begin
                    // SCL rises first, SDA rises while SCL is high
                    bus.sda_out <= (phase == 2'd2);
                    bus.scl_out <= (phase != 2'd0);
                    if (phase == 2'd2) begin
                        phase <= 2'd0;
                        state <= DONE;
                    end else begin
                        phase <= phase + 2'd1;
                    end
                end
                DONE: begin
                    bus.sda_out  <= 1'b1;
                    bus.scl_out  <= 1'b1;
                    bus.finished <= 1'b1;
                    bus.ack      <= (bus.nack_idx == NO_NACK);
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_write_engine.sv
// tb_i2c_write_engine
//   Drives a SEND_REG=0 and a SEND_REG=1 engine with identical requests.
//   A per-engine bus monitor decodes bytes at SCL rising edges, counts
//   START/STOP conditions, acts as the slave (ACK/NACK per byte position)
//   and timestamps finished. Results are compared with a transaction-level
//   model of the expected byte list, latency and NACK index.
module tb_i2c_write_engine;
    logic slowclk = 1'b0;
    logic rstn;
    logic mon_clr;
    logic [2:0] mask_r;   // NACK per transmitted byte position
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 slowclk = ~slowclk;
    always @(posedge slowclk) cyc <= cyc + 1;

    i2c_write_engine_if bi0 ();
    i2c_write_engine_if bi1 ();

    i2c_write_engine #(.SEND_REG(1'b0)) dut0 (.slowclk(slowclk), .rstn(rstn), .bus(bi0));
    i2c_write_engine #(.SEND_REG(1'b1)) dut1 (.slowclk(slowclk), .rstn(rstn), .bus(bi1));

    typedef struct packed {
        logic            pscl;
        logic            psd;
        logic            drv;
        logic [3:0]      bitn;
        logic [7:0]      sh;
        logic [2:0][7:0] b;
        logic [2:0]      nb;
        logic [7:0]      starts;
        logic [7:0]      stops;
        logic [7:0]      fins;
        logic [31:0]     fin_first;
        logic [31:0]     fin_2nd;
        logic            fack;
        logic [1:0]      fnidx;
    } mon_t;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] r;
        logic [7:0] d;
        logic [2:0] mask;
        logic [7:0] lat1;
        logic [1:0] nidx1;
    } vec_t;

    mon_t m0, m1;

    task automatic mon_step(input logic sc, input logic sd, input logic fin, input logic ak,
                            input logic [1:0] ni, input logic [2:0] mask, input logic clr,
                            inout mon_t m);
        if (clr) begin
            m = '0;
        end else begin
            if (m.pscl && sc && (m.psd != sd)) begin
                if (sd) m.stops = m.stops + 8'd1;
                else    m.starts = m.starts + 8'd1;
            end
            if (!m.pscl && sc) begin
                if (m.bitn < 4'd8) begin
                    m.sh   = {m.sh[6:0], sd};
                    m.bitn = m.bitn + 4'd1;
                    if (m.bitn == 4'd8 && m.nb < 3'd3) begin
                        m.b[m.nb] = m.sh;
                        m.nb      = m.nb + 3'd1;
                    end
                end else begin
                    m.bitn = 4'd0;
                    m.drv  = (m.nb != 3'd0) ? mask[m.nb - 3'd1] : 1'b0;
                end
            end
            if (m.pscl && !sc) m.drv = 1'b0;
            if (fin) begin
                m.fins = m.fins + 8'd1;
                if (m.fins == 8'd1) m.fin_first = cyc;
                if (m.fins == 8'd2) m.fin_2nd = cyc;
                m.fack  = ak;
                m.fnidx = ni;
            end
        end
        m.pscl = sc;
        m.psd  = sd;
    endtask

    initial begin
        m0 = '0;
        bi0.sda_in = 1'b0;
        forever begin
            @(negedge slowclk);
            mon_step(bi0.scl_out, bi0.sda_out, bi0.finished, bi0.ack, bi0.nack_idx, mask_r, mon_clr, m0);
            bi0.sda_in = m0.drv;
        end
    end

    initial begin
        m1 = '0;
        bi1.sda_in = 1'b0;
        forever begin
            @(negedge slowclk);
            mon_step(bi1.scl_out, bi1.sda_out, bi1.finished, bi1.ack, bi1.nack_idx, mask_r, mon_clr, m1);
            bi1.sda_in = m1.drv;
        end
    end

    // Transaction model: byte list in send order, stop at the first NACKed
    // position; each sent byte costs 9 bits of 4 quarters.
    function automatic void model(input bit sr, input logic [6:0] a, input logic [7:0] r,
                                  input logic [7:0] d, input logic [2:0] mask,
                                  output logic [2:0][7:0] eb, output int enb,
                                  output int elat, output logic [1:0] enidx);
        logic [7:0] seq[$];
        int ids[$];
        seq.push_back({a, 1'b0}); ids.push_back(0);
        if (sr) begin seq.push_back(r); ids.push_back(1); end
        seq.push_back(d); ids.push_back(2);
        eb = '0; enb = 0; enidx = 2'd3;
        for (int i = 0; i < seq.size(); i++) begin
            eb[i] = seq[i];
            enb++;
            if (mask[i]) begin
                enidx = 2'(ids[i]);
                break;
            end
        end
        elat = 2 + enb * 36 + 3 + 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d);
        bi0.address = a; bi0.reg_addr = r; bi0.data = d;
        bi1.address = a; bi1.reg_addr = r; bi1.data = d;
    endtask

    task automatic drive_start(input logic s);
        bi0.start = s;
        bi1.start = s;
    endtask

    task automatic clr_mon();
        @(negedge slowclk); #1 mon_clr = 1'b1;
        @(negedge slowclk); #1 mon_clr = 1'b0;
    endtask

    task automatic run(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d,
                       input logic [2:0] mask, input bit disturb, output int t0);
        clr_mon();
        set_in(a, r, d);
        mask_r = mask;
        drive_start(1'b1);
        t0 = cyc + 1;
        for (int n = 0; n < 400; n++) begin
            @(negedge slowclk); #1;
            if (disturb && cyc == t0 + 30) set_in(~a, ~r, ~d);
            drive_start(disturb && cyc == t0 + 50);
            if (m0.fins != 0 && m1.fins != 0) break;
        end
        drive_start(1'b0);
        repeat (4) begin @(negedge slowclk); #1; end
    endtask

    task automatic check_all(input bit sel, input logic [6:0] a, input logic [7:0] r,
                             input logic [7:0] d, input logic [2:0] mask, input int t0);
        logic [2:0][7:0] eb;
        int enb, elat;
        logic [1:0] enidx;
        mon_t m;
        logic bz;
        string p;
        model(sel, a, r, d, mask, eb, enb, elat, enidx);
        m  = sel ? m1 : m0;
        bz = sel ? bi1.busy : bi0.busy;
        p  = sel ? "r1" : "r0";
        chk({p, "_nbytes"}, int'(m.nb), enb);
        for (int i = 0; i < enb; i++) chk($sformatf("%s_byte%0d", p, i), int'(m.b[i]), int'(eb[i]));
        chk({p, "_latency"}, int'(m.fin_first) - t0, elat);
        chk({p, "_fin_pulses"}, int'(m.fins), 1);
        chk({p, "_ack"}, int'(m.fack), int'(enidx == 2'd3));
        chk({p, "_nack_idx"}, int'(m.fnidx), int'(enidx));
        chk({p, "_starts"}, int'(m.starts), 1);
        chk({p, "_stops"}, int'(m.stops), 1);
        chk({p, "_busy_after"}, int'(bz), 0);
    endtask

    vec_t vt[6];

    initial begin
        int t0;
        logic [6:0] ra;
        logic [7:0] rr, rd;
        logic [2:0] rm;

        vt[0] = '{7'h3F, 8'h10, 8'hF0, 3'b000, 8'd114, 2'd3};
        vt[1] = '{7'h3F, 8'h10, 8'hF0, 3'b001, 8'd42,  2'd0};
        vt[2] = '{7'h55, 8'hA5, 8'h5A, 3'b100, 8'd114, 2'd2};
        vt[3] = '{7'h12, 8'h34, 8'h56, 3'b010, 8'd78,  2'd1};
        vt[4] = '{7'h3F, 8'h10, 8'h0F, 3'b000, 8'd114, 2'd3};
        vt[5] = '{7'h7F, 8'hFF, 8'h00, 3'b110, 8'd78,  2'd1};

        rstn = 1'b0; mon_clr = 1'b0; mask_r = 3'b000;
        set_in('0, '0, '0);
        drive_start(1'b0);
        repeat (2) @(posedge slowclk);
        @(negedge slowclk); #1;
        chk("rst_sda0", int'(bi0.sda_out), 1);   chk("rst_sda1", int'(bi1.sda_out), 1);
        chk("rst_scl0", int'(bi0.scl_out), 1);   chk("rst_scl1", int'(bi1.scl_out), 1);
        chk("rst_busy0", int'(bi0.busy), 0);     chk("rst_busy1", int'(bi1.busy), 0);
        chk("rst_fin0", int'(bi0.finished), 0);  chk("rst_fin1", int'(bi1.finished), 0);
        chk("rst_ack0", int'(bi0.ack), 0);       chk("rst_ack1", int'(bi1.ack), 0);
        chk("rst_nidx0", int'(bi0.nack_idx), 3); chk("rst_nidx1", int'(bi1.nack_idx), 3);
        rstn = 1'b1;

        foreach (vt[i]) begin
            run(vt[i].a, vt[i].r, vt[i].d, vt[i].mask, 1'b0, t0);
            chk($sformatf("tab%0d_lat1", i), int'(m1.fin_first) - t0, int'(vt[i].lat1));
            chk($sformatf("tab%0d_nidx1", i), int'(m1.fnidx), int'(vt[i].nidx1));
            check_all(1'b1, vt[i].a, vt[i].r, vt[i].d, vt[i].mask, t0);
            check_all(1'b0, vt[i].a, vt[i].r, vt[i].d, vt[i].mask, t0);
        end

        // restart request and input changes while busy
        run(7'h3F, 8'h10, 8'hF0, 3'b000, 1'b1, t0);
        check_all(1'b1, 7'h3F, 8'h10, 8'hF0, 3'b000, t0);
        check_all(1'b0, 7'h3F, 8'h10, 8'hF0, 3'b000, t0);

        // start held high: back-to-back accept right after completion
        clr_mon();
        set_in(7'h21, 8'h42, 8'h84);
        mask_r = 3'b000;
        drive_start(1'b1);
        t0 = cyc + 1;
        for (int n = 0; n < 400 && m1.fins < 8'd2; n++) begin @(negedge slowclk); #1; end
        drive_start(1'b0);
        chk("held_lat1", int'(m1.fin_first) - t0, 114);
        chk("held_gap1", int'(m1.fin_2nd) - int'(m1.fin_first), 115);
        chk("held_lat0", int'(m0.fin_first) - t0, 78);
        chk("held_gap0", int'(m0.fin_2nd) - int'(m0.fin_first), 79);

        // asynchronous reset mid-byte releases the bus at once
        clr_mon();
        set_in('0, '0, '0);
        drive_start(1'b1);
        t0 = cyc + 1;
        @(negedge slowclk); #1 drive_start(1'b0);
        while (cyc < t0 + 20) begin @(negedge slowclk); #1; end
        chk("pre_rst_busy1", int'(bi1.busy), 1);
        chk("pre_rst_sda1", int'(bi1.sda_out), 0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_sda1", int'(bi1.sda_out), 1);  chk("arst_scl1", int'(bi1.scl_out), 1);
        chk("arst_busy1", int'(bi1.busy), 0);    chk("arst_sda0", int'(bi0.sda_out), 1);
        chk("arst_scl0", int'(bi0.scl_out), 1);  chk("arst_busy0", int'(bi0.busy), 0);
        repeat (2) @(negedge slowclk);
        #1 rstn = 1'b1;
        chk("arst_nidx1", int'(bi1.nack_idx), 3);
        chk("arst_ack1", int'(bi1.ack), 0);
        run(7'h3F, 8'h10, 8'hF0, 3'b000, 1'b0, t0);
        check_all(1'b1, 7'h3F, 8'h10, 8'hF0, 3'b000, t0);
        check_all(1'b0, 7'h3F, 8'h10, 8'hF0, 3'b000, t0);

        // randomized transfers against the model
        for (int k = 0; k < 6; k++) begin
            ra = 7'($urandom);
            rr = 8'($urandom);
            rd = 8'($urandom);
            for (int j = 0; j < 3; j++) rm[j] = ($urandom_range(0, 3) == 0);
            run(ra, rr, rd, rm, 1'b0, t0);
            check_all(1'b1, ra, rr, rd, rm, t0);
            check_all(1'b0, ra, rr, rd, rm, t0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
